// File: rtl/round_ctrl.sv
// Round controller for a two-tank game: start/play/respawn/game-over sequencing,
// score keeping and per-tank shield energy with slow recharge.
module round_ctrl #(
    parameter int WIN_SCORE      = 5,
    parameter int RESPAWN_FRAMES = 60,
    parameter int OVER_FRAMES    = 300,
    parameter int SHIELD_MAX     = 120
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       hit1,
    input  logic       hit2,
    input  logic       shield_req1,
    input  logic       shield_req2,
    output logic       respawn1,
    output logic       respawn2,
    output logic       game_over_display,
    output logic       game_over_display2,
    output logic       freeze,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       shield_on1,
    output logic       shield_on2,
    output logic [7:0] energy1,
    output logic [7:0] energy2,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_RESPAWN = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    localparam logic [7:0] KEY_ENTER   = 8'h28;
    localparam logic [3:0] WIN         = 4'(WIN_SCORE);
    localparam logic [8:0] RESP_LOAD   = 9'(RESPAWN_FRAMES - 1);
    localparam logic [8:0] OVER_LOAD   = 9'(OVER_FRAMES - 1);
    localparam logic [7:0] SHIELD_FULL = 8'(SHIELD_MAX);

    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [3:0] score1_q, score1_d, score2_q, score2_d;
    logic [7:0] energy1_q, energy1_d, energy2_q, energy2_d;
    logic [1:0] presc_q, presc_d;
    logic       shield_on1_q, shield_on1_d, shield_on2_q, shield_on2_d;
    logic       respawn1_q, respawn1_d, respawn2_q, respawn2_d;
    logic       start, eh1, eh2;

    // Drain while the shield is up; otherwise recharge once per prescaler wrap.
    function automatic logic [7:0] next_energy(input logic [7:0] e, input logic on,
                                               input logic [1:0] presc);
        logic [7:0] r;
        r = e;
        if (on) begin
            if (e != 8'd0)
                r = e - 8'd1;
        end else if (presc == 2'd3 && e < SHIELD_FULL) begin
            r = e + 8'd1;
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        respawn1_d = 1'b0;
        respawn2_d = 1'b0;
        start      = 1'b0;
        eh1        = hit1 & ~shield_on1_q;
        eh2        = hit2 & ~shield_on2_q;

        case (state_q)
            S_IDLE: begin
                if (keycode == KEY_ENTER) begin
                    start    = 1'b1;
                    state_d  = S_PLAY;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                end
            end
            S_PLAY: begin
                if (eh1 || eh2) begin
                    if (eh1) begin
                        respawn1_d = 1'b1;
                        if (score2_q < WIN)
                            score2_d = score2_q + 4'd1;
                    end
                    if (eh2) begin
                        respawn2_d = 1'b1;
                        if (score1_q < WIN)
                            score1_d = score1_q + 4'd1;
                    end
                    if (score1_d == WIN || score2_d == WIN) begin
                        state_d = S_OVER;
                        cnt_d   = OVER_LOAD;
                    end else begin
                        state_d = S_RESPAWN;
                        cnt_d   = RESP_LOAD;
                    end
                end
            end
            S_RESPAWN: begin
                if (cnt_q == 9'd0)
                    state_d = S_PLAY;
                else
                    cnt_d = cnt_q - 9'd1;
            end
            default: begin
                if (cnt_q == 9'd0 || keycode == KEY_ENTER) begin
                    state_d = S_IDLE;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
        endcase

        presc_d      = presc_q + 2'd1;
        // Shield sees the energy before this edge's drain, so it drops one edge after hitting zero.
        shield_on1_d = (state_q == S_PLAY) & shield_req1 & (energy1_q != 8'd0);
        shield_on2_d = (state_q == S_PLAY) & shield_req2 & (energy2_q != 8'd0);
        energy1_d    = start ? SHIELD_FULL : next_energy(energy1_q, shield_on1_q, presc_q);
        energy2_d    = start ? SHIELD_FULL : next_energy(energy2_q, shield_on2_q, presc_q);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 9'd0;
            score1_q     <= 4'd0;
            score2_q     <= 4'd0;
            energy1_q    <= SHIELD_FULL;
            energy2_q    <= SHIELD_FULL;
            presc_q      <= 2'd0;
            shield_on1_q <= 1'b0;
            shield_on2_q <= 1'b0;
            respawn1_q   <= 1'b0;
            respawn2_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            energy1_q    <= energy1_d;
            energy2_q    <= energy2_d;
            presc_q      <= presc_d;
            shield_on1_q <= shield_on1_d;
            shield_on2_q <= shield_on2_d;
            respawn1_q   <= respawn1_d;
            respawn2_q   <= respawn2_d;
        end
    end

    assign state              = state_q;
    assign freeze             = (state_q != S_PLAY);
    assign game_over_display  = (state_q == S_OVER) && (score1_q == WIN);
    assign game_over_display2 = (state_q == S_OVER) && (score2_q == WIN);
    assign score1             = score1_q;
    assign score2             = score2_q;
    assign energy1            = energy1_q;
    assign energy2            = energy2_q;
    assign shield_on1         = shield_on1_q;
    assign shield_on2         = shield_on2_q;
    assign respawn1           = respawn1_q;
    assign respawn2           = respawn2_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with default parameters (5 / 60 / 300 / 120).
module tb_round_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       hit1 = 1'b0, hit2 = 1'b0;
    logic       shield_req1 = 1'b0, shield_req2 = 1'b0;
    logic       respawn1, respawn2, game_over_display, game_over_display2, freeze;
    logic [3:0] score1, score2;
    logic       shield_on1, shield_on2;
    logic [7:0] energy1, energy2;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    round_ctrl dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .hit1(hit1), .hit2(hit2), .shield_req1(shield_req1), .shield_req2(shield_req2),
        .respawn1(respawn1), .respawn2(respawn2),
        .game_over_display(game_over_display), .game_over_display2(game_over_display2),
        .freeze(freeze), .score1(score1), .score2(score2),
        .shield_on1(shield_on1), .shield_on2(shield_on2),
        .energy1(energy1), .energy2(energy2), .state(state)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic hit(input logic h1, input logic h2);
        hit1 = h1;
        hit2 = h2;
        step();
        hit1 = 1'b0;
        hit2 = 1'b0;
        $display("hit1=%0b hit2=%0b -> state=%0d score=%0d/%0d respawn=%0b%0b",
                 h1, h2, state, score1, score2, respawn1, respawn2);
    endtask

    task automatic press_enter();
        keycode = 8'h28;
        step();
        keycode = 8'h00;
        $display("enter -> state=%0d", state);
    endtask

    initial begin
        // reset state
        step(2);
        check("rst_state", state, 0);
        check("rst_freeze", freeze, 1);
        check("rst_scores", {score1, score2}, 0);
        check("rst_energy1", energy1, 120);
        check("rst_energy2", energy2, 120);
        check("rst_outs", {respawn1, respawn2, game_over_display, game_over_display2,
                           shield_on1, shield_on2}, 0);
        Reset = 1'b0;
        step(3);
        check("idle_hold", state, 0);

        // start a round
        press_enter();
        check("start_state", state, 1);
        check("start_freeze", freeze, 0);
        check("start_scores", {score1, score2}, 0);
        check("start_energy", {energy1, energy2}, {8'd120, 8'd120});

        // single scoring hit and respawn timing
        hit(1'b0, 1'b1);
        check("hit2_score1", score1, 1);
        check("hit2_score2", score2, 0);
        check("hit2_resp", {respawn1, respawn2}, 2'b01);
        check("hit2_state", state, 2);
        check("resp_freeze", freeze, 1);
        step();
        check("resp_pulse_len", {respawn1, respawn2}, 0);
        hit(1'b1, 1'b0);
        check("resp_hit_ignored", {score1, score2}, {4'd1, 4'd0});
        step(57);
        check("resp_59", state, 2);
        step();
        check("resp_60", state, 1);

        // reset in the middle of a respawn freeze
        hit(1'b1, 1'b0);
        check("hit1_score2", score2, 1);
        check("no_go_in_resp", {game_over_display, game_over_display2}, 0);
        step(29);
        #3 Reset = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_freeze", freeze, 1);
        check("arst_scores", {score1, score2}, 0);
        check("arst_resp", {respawn1, respawn2}, 0);
        Reset = 1'b0;
        step();
        $display("async reset mid-respawn -> state=%0d", state);

        // draw: 4/4 then a double hit
        press_enter();
        for (int i = 1; i <= 4; i++) begin
            hit(1'b1, 1'b1);
            check("dbl_scores", {score1, score2}, {4'(i), 4'(i)});
            check("dbl_resp", {respawn1, respawn2}, 2'b11);
            check("dbl_state", state, 2);
            step(60);
            check("dbl_back", state, 1);
        end
        hit(1'b1, 1'b1);
        check("draw_scores", {score1, score2}, {4'd5, 4'd5});
        check("draw_state", state, 3);
        check("draw_go", {game_over_display, game_over_display2}, 2'b11);
        check("draw_freeze", freeze, 1);
        step(299);
        check("over_299", state, 3);
        step();
        check("over_300", state, 0);
        check("idle_go", {game_over_display, game_over_display2}, 0);
        check("idle_held", {score1, score2}, {4'd5, 4'd5});

        // single winner, then Enter held through OVER -> IDLE -> PLAY
        press_enter();
        check("restart_scores", {score1, score2}, 0);
        for (int i = 1; i <= 4; i++) begin
            hit(1'b0, 1'b1);
            check("win_score1", score1, i);
            step(60);
        end
        hit(1'b0, 1'b1);
        check("win_state", state, 3);
        check("win_go", {game_over_display, game_over_display2}, 2'b10);
        check("win_cap", score1, 5);
        keycode = 8'h28;
        step();
        check("enter_over", state, 0);
        check("enter_held_score", score1, 5);
        step();
        keycode = 8'h00;
        check("enter_level", state, 1);
        check("enter_clear", {score1, score2}, 0);

        // shielded hit ignored, drain to zero, drop, recharge
        shield_req1 = 1'b1;
        step();
        check("shield_up", shield_on1, 1);
        hit(1'b1, 1'b0);
        check("shield_block", {score1, score2}, 0);
        check("shield_block_state", state, 1);
        for (int i = 0; i < 200 && energy1 != 8'd2; i++)
            step();
        check("drain_e2", energy1, 2);
        check("drain_other", energy2, 120);
        step();
        check("drain_e1", {shield_on1, energy1}, {1'b1, 8'd1});
        step();
        check("drain_e0", {shield_on1, energy1}, {1'b1, 8'd0});
        step();
        check("shield_drop", shield_on1, 0);
        check("e0_hold", energy1, 0);
        shield_req1 = 1'b0;
        step(12);
        check("recharge_12", energy1, 3);
        $display("recharge after 12 frames -> energy1=%0d", energy1);
        hit(1'b1, 1'b0);
        check("late_hit", score2, 1);
        check("late_hit_state", state, 2);
        step(600);
        check("sat_energy1", energy1, 120);
        check("sat_energy2", energy2, 120);
        check("sat_state", state, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
